// File: rtl/frame_stream_ctrl.sv
// ============================================================================
// Module   : frame_stream_ctrl
// Brief    : Frame gate and two-word trailer inserter for the 64-bit pixel stream.
// Revision : 1.0
// ============================================================================
`default_nettype none

module frame_stream_ctrl #(
    parameter int          DATA_WD       = 64,
    parameter int          FRAME_CNT_WD  = 16,
    parameter int          WORD_CNT_WD   = 32,
    parameter logic [15:0] TRAILER_MAGIC = 16'h5AA5
) (
    input  logic                    clk_pix_2x,
    input  logic                    reset_pix_2x,
    input  logic                    i_fval,
    input  logic                    i_data_valid,
    input  logic [DATA_WD-1:0]      iv_data,
    input  logic                    i_acquisition_start,
    input  logic                    i_stream_enable,
    input  logic                    i_encrypt_state,
    input  logic [31:0]             iv_exp_words,
    output logic                    o_fval,
    output logic                    o_data_valid,
    output logic [DATA_WD-1:0]      ov_data,
    output logic                    o_trailer,
    output logic [FRAME_CNT_WD-1:0] ov_frame_id,
    output logic                    o_frame_drop
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ACTIVE   = 3'd1,
        S_TRAILER0 = 3'd2,
        S_TRAILER1 = 3'd3,
        S_SKIP     = 3'd4
    } state_t;

    state_t                  state_q;
    logic                    fval_d_q;
    logic [FRAME_CNT_WD-1:0] frame_id_q;
    logic [WORD_CNT_WD-1:0]  word_cnt_q;
    logic [WORD_CNT_WD-1:0]  word_cnt_d;
    logic [31:0]             exp_words_q;
    logic                    sat_flag_q;
    logic                    o_fval_q;
    logic                    o_data_valid_q;
    logic [DATA_WD-1:0]      ov_data_q;
    logic                    o_trailer_q;
    logic                    o_frame_drop_q;

    logic                    w_rise;
    logic                    w_en;
    logic                    w_cnt_max;
    logic                    w_mismatch;
    logic [63:0]             w_trailer0;
    logic [63:0]             w_trailer1;

    assign w_rise     = i_fval & ~fval_d_q;
    assign w_en       = i_acquisition_start & i_stream_enable & i_encrypt_state;
    assign w_cnt_max  = &word_cnt_q;
    assign word_cnt_d = word_cnt_q + 1'b1;
    assign w_mismatch = (32'(word_cnt_q) != exp_words_q);
    assign w_trailer0 = {TRAILER_MAGIC, 16'(frame_id_q), 32'(word_cnt_q)};
    assign w_trailer1 = {TRAILER_MAGIC, 46'b0, sat_flag_q, w_mismatch};

    always_ff @(posedge clk_pix_2x) begin
        if (reset_pix_2x) begin
            state_q        <= S_IDLE;
            fval_d_q       <= 1'b0;
            frame_id_q     <= '0;
            word_cnt_q     <= '0;
            exp_words_q    <= '0;
            sat_flag_q     <= 1'b0;
            o_fval_q       <= 1'b0;
            o_data_valid_q <= 1'b0;
            ov_data_q      <= '0;
            o_trailer_q    <= 1'b0;
            o_frame_drop_q <= 1'b0;
        end else begin
            fval_d_q       <= i_fval;
            o_trailer_q    <= 1'b0;
            o_frame_drop_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    o_fval_q       <= 1'b0;
                    o_data_valid_q <= 1'b0;
                    if (w_rise && w_en) begin
                        // The start cycle already carries payload, so it is handled as ACTIVE.
                        state_q        <= S_ACTIVE;
                        o_fval_q       <= 1'b1;
                        o_data_valid_q <= i_data_valid;
                        if (i_data_valid) begin
                            ov_data_q <= iv_data;
                        end
                        word_cnt_q     <= WORD_CNT_WD'(i_data_valid);
                        sat_flag_q     <= 1'b0;
                        exp_words_q    <= iv_exp_words;
                    end else if (w_rise) begin
                        state_q        <= S_SKIP;
                        o_frame_drop_q <= 1'b1;
                    end
                end
                S_ACTIVE: begin
                    o_fval_q <= 1'b1;
                    if (i_fval) begin
                        o_data_valid_q <= i_data_valid;
                        if (i_data_valid) begin
                            ov_data_q <= iv_data;
                            // A word arriving with the counter pinned is uncounted; flag it.
                            if (w_cnt_max) begin
                                sat_flag_q <= 1'b1;
                            end else begin
                                word_cnt_q <= word_cnt_d;
                            end
                        end
                    end else begin
                        state_q        <= S_TRAILER0;
                        o_data_valid_q <= 1'b0;
                    end
                end
                S_TRAILER0: begin
                    state_q        <= S_TRAILER1;
                    o_fval_q       <= 1'b1;
                    o_data_valid_q <= 1'b1;
                    o_trailer_q    <= 1'b1;
                    ov_data_q      <= DATA_WD'(w_trailer0);
                end
                S_TRAILER1: begin
                    o_fval_q       <= 1'b1;
                    o_data_valid_q <= 1'b1;
                    o_trailer_q    <= 1'b1;
                    ov_data_q      <= DATA_WD'(w_trailer1);
                    frame_id_q     <= frame_id_q + 1'b1;
                    // A frame that began under the trailer has lost its start; reject it whole.
                    if (i_fval) begin
                        state_q        <= S_SKIP;
                        o_frame_drop_q <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_SKIP: begin
                    o_fval_q       <= 1'b0;
                    o_data_valid_q <= 1'b0;
                    if (!i_fval) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q        <= S_IDLE;
                    o_fval_q       <= 1'b0;
                    o_data_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_fval       = o_fval_q;
    assign o_data_valid = o_data_valid_q;
    assign ov_data      = ov_data_q;
    assign o_trailer    = o_trailer_q;
    assign ov_frame_id  = frame_id_q;
    assign o_frame_drop = o_frame_drop_q;

endmodule

`default_nettype wire

// File: tb/tb_frame_stream_ctrl.sv
// ============================================================================
// Module   : tb_frame_stream_ctrl
// Brief    : Scoreboard bench for frame_stream_ctrl with directed frame sequences.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_frame_stream_ctrl;

    logic        clk;
    logic        rst;
    logic        i_fval;
    logic        i_data_valid;
    logic [63:0] iv_data;
    logic        i_acquisition_start;
    logic        i_stream_enable;
    logic        i_encrypt_state;
    logic [31:0] iv_exp_words;
    logic        o_fval;
    logic        o_data_valid;
    logic [63:0] ov_data;
    logic        o_trailer;
    logic [15:0] ov_frame_id;
    logic        o_frame_drop;

    int          checks;
    int          errors;
    int          drop_cnt;
    logic [64:0] exp_q[$];

    frame_stream_ctrl dut (
        .clk_pix_2x          (clk),
        .reset_pix_2x        (rst),
        .i_fval              (i_fval),
        .i_data_valid        (i_data_valid),
        .iv_data             (iv_data),
        .i_acquisition_start (i_acquisition_start),
        .i_stream_enable     (i_stream_enable),
        .i_encrypt_state     (i_encrypt_state),
        .iv_exp_words        (iv_exp_words),
        .o_fval              (o_fval),
        .o_data_valid        (o_data_valid),
        .ov_data             (ov_data),
        .o_trailer           (o_trailer),
        .ov_frame_id         (ov_frame_id),
        .o_frame_drop        (o_frame_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic f, input logic v, input logic [63:0] d);
        i_fval       = f;
        i_data_valid = v;
        iv_data      = d;
        @(posedge clk);
        #1;
    endtask

    task automatic low(input int k);
        repeat (k) cyc(1'b0, 1'b0, 64'h0);
    endtask

    // Drives n valid words base..base+n-1; toggle_at flips i_stream_enable mid-frame.
    task automatic send_frame(input int n, input bit gaps, input logic [63:0] base,
                              input bit admit, input int toggle_at);
        for (int i = 0; i < n; i++) begin
            if (i == toggle_at) i_stream_enable = ~i_stream_enable;
            if (gaps && i > 0) cyc(1'b1, 1'b0, 64'hDEAD_BEEF_0000_0000);
            cyc(1'b1, 1'b1, base + 64'(i));
            if (admit) exp_q.push_back({1'b0, base + 64'(i)});
        end
    endtask

    task automatic push_trailers(input logic [15:0] fid, input logic [31:0] cnt, input logic mm);
        exp_q.push_back({1'b1, 16'h5AA5, fid, cnt});
        exp_q.push_back({1'b1, 16'h5AA5, 46'b0, 1'b0, mm});
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [64:0] e;
        forever begin
            @(negedge clk);
            if (o_frame_drop) drop_cnt++;
            if (o_data_valid) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL mon_unexpected act=%b_%h exp=none", o_trailer, ov_data);
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if ({o_trailer, ov_data} !== e) begin
                        errors++;
                        $display("FAIL mon_word act=%b_%h exp=%b_%h", o_trailer, ov_data, e[64], e[63:0]);
                    end
                end
                if (!o_fval) begin
                    errors++;
                    $display("FAIL mon_fval act=%b exp=1", o_fval);
                end
            end else if (o_trailer) begin
                errors++;
                $display("FAIL mon_trailer_idle act=%b exp=0", o_trailer);
            end
        end
    end

    initial begin
        checks = 0; errors = 0; drop_cnt = 0;
        rst = 1'b1;
        i_acquisition_start = 1'b1; i_stream_enable = 1'b1; i_encrypt_state = 1'b1;
        iv_exp_words = 32'd0;
        low(3);
        rst = 1'b0;
        low(1);
        chk("rst_fval", 64'(o_fval), 64'd0);
        chk("rst_dv", 64'(o_data_valid), 64'd0);
        chk("rst_data", ov_data, 64'd0);
        chk("rst_trailer", 64'(o_trailer), 64'd0);
        chk("rst_id", 64'(ov_frame_id), 64'd0);
        chk("rst_drop", 64'(o_frame_drop), 64'd0);

        // Rejected at rise, enable returns mid-frame: whole frame suppressed.
        i_stream_enable = 1'b0;
        send_frame(6, 1'b0, 64'h100, 1'b0, 2);
        low(4);
        drain("drain_reject");
        chk("reject_drop", 64'(drop_cnt), 64'd1);
        chk("reject_id", 64'(ov_frame_id), 64'd0);

        // Basic frame of 8 words, exp=8.
        iv_exp_words = 32'd8;
        send_frame(8, 1'b0, 64'h0, 1'b1, -1);
        push_trailers(16'd0, 32'd8, 1'b0);
        low(4);
        drain("drain_basic");
        chk("basic_id", 64'(ov_frame_id), 64'd1);
        chk("basic_fval_low", 64'(o_fval), 64'd0);

        // Enable drops mid-frame: frame completes, next frame rejected.
        iv_exp_words = 32'd16;
        send_frame(16, 1'b0, 64'h200, 1'b1, 5);
        push_trailers(16'd1, 32'd16, 1'b0);
        low(4);
        send_frame(5, 1'b0, 64'h300, 1'b0, -1);
        low(3);
        drain("drain_middrop");
        chk("middrop_drop", 64'(drop_cnt), 64'd2);
        chk("middrop_id", 64'(ov_frame_id), 64'd2);

        // fval re-rises one cycle after falling: trailers sent, that frame skipped.
        i_stream_enable = 1'b1;
        iv_exp_words = 32'd4;
        send_frame(4, 1'b0, 64'h400, 1'b1, -1);
        push_trailers(16'd2, 32'd4, 1'b0);
        low(1);
        send_frame(6, 1'b0, 64'h500, 1'b0, -1);
        low(3);
        iv_exp_words = 32'd3;
        send_frame(3, 1'b0, 64'h600, 1'b1, -1);
        push_trailers(16'd3, 32'd3, 1'b0);
        low(4);
        drain("drain_rerise");
        chk("rerise_drop", 64'(drop_cnt), 64'd3);
        chk("rerise_id", 64'(ov_frame_id), 64'd4);

        // Three gapped frames with 9 words against exp=10.
        rst = 1'b1;
        low(1);
        rst = 1'b0;
        chk("rst2_id", 64'(ov_frame_id), 64'd0);
        iv_exp_words = 32'd10;
        for (int k = 0; k < 3; k++) begin
            send_frame(9, 1'b1, 64'h700 + 64'(k * 16), 1'b1, -1);
            push_trailers(16'(k), 32'd9, 1'b1);
            low(4);
        end
        drain("drain_gaps");
        chk("gaps_id", 64'(ov_frame_id), 64'd3);

        // Reset mid-frame aborts it with no trailer.
        iv_exp_words = 32'd5;
        send_frame(5, 1'b0, 64'h800, 1'b1, -1);
        rst = 1'b1;
        cyc(1'b1, 1'b1, 64'h805);
        rst = 1'b0;
        chk("midrst_fval", 64'(o_fval), 64'd0);
        chk("midrst_dv", 64'(o_data_valid), 64'd0);
        chk("midrst_data", ov_data, 64'd0);
        chk("midrst_id", 64'(ov_frame_id), 64'd0);
        low(4);
        drain("drain_midrst");
        send_frame(2, 1'b0, 64'h900, 1'b1, -1);
        push_trailers(16'd0, 32'd2, 1'b1);
        low(4);
        drain("drain_after_rst");
        chk("after_rst_id", 64'(ov_frame_id), 64'd1);
        chk("final_drop", 64'(drop_cnt), 64'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
